// File: rtl/spi_arb.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb
// Purpose  : Two-requester round-robin arbiter in front of a 16-bit SPI
//            master (mode 3: CPOL=1, CPHA=1). One accepted request becomes
//            one chip-select frame. The word shifted in on spi_miso is
//            returned on the response port, tagged with the requester index.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SCK_HALF  SCK half-period in clk_sys cycles (1..15)
//   GAP       minimum spi_csn-high cycles between frames (1..15)
// Ports
//   clk_sys              in   system clock, rising edge
//   rst                  in   synchronous active-high reset
//   req0_vld/req0_data   in   requester 0 frame request / tx word
//   req0_rdy             out  requester 0 accept pulse (IDLE only)
//   req1_vld/req1_data   in   requester 1 frame request / tx word
//   req1_rdy             out  requester 1 accept pulse (IDLE only)
//   rsp_vld              out  one-cycle frame-complete pulse
//   rsp_id               out  requester that owned the completed frame
//   rsp_data             out  received word, first bit in MSB
//   busy                 out  high when not IDLE
//   spi_csn/sck/mosi     out  registered SPI master outputs
//   spi_miso             in   SPI slave data
// ============================================================================
module spi_arb #(
  parameter int SCK_HALF = 5,
  parameter int GAP      = 4
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        req0_vld,
  input  logic [15:0] req0_data,
  output logic        req0_rdy,
  input  logic        req1_vld,
  input  logic [15:0] req1_data,
  output logic        req1_rdy,
  output logic        rsp_vld,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [3:0] C_HALF_LAST = 4'(SCK_HALF - 1);
  localparam logic [3:0] C_GAP_LAST  = 4'(GAP - 1);
  localparam logic [4:0] C_LAST_HALF = 5'd31;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  // Index of the current SCK half-period inside SHIFT: even = low, odd = high
  logic [4:0]  r_half, w_half_nxt;
  logic [15:0] r_tx, w_tx_nxt;
  logic [15:0] r_rx, w_rx_nxt;
  logic        r_id, w_id_nxt;
  logic        r_last_id, w_last_id_nxt;
  logic        r_csn, w_csn_nxt;
  logic        r_sck, w_sck_nxt;
  logic        r_mosi, w_mosi_nxt;
  logic        r_rsp_vld, w_rsp_vld_nxt;
  logic        r_rsp_id, w_rsp_id_nxt;
  logic [15:0] r_rsp_data, w_rsp_data_nxt;

  logic        w_gnt0;
  logic        w_gnt1;
  logic [15:0] w_sel_data;
  logic        w_half_end;

  // --------------------------------------------------------------------------
  // Arbitration: only in IDLE and never during reset. On contention the
  // requester that was not granted last wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst && (r_state == S_IDLE)) begin
      if (req0_vld && (!req1_vld || r_last_id)) begin
        w_gnt0 = 1'b1;
      end else if (req1_vld) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_sel_data = w_gnt1 ? req1_data : req0_data;
  assign w_half_end = (r_cnt == C_HALF_LAST);

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. The SPI pins are computed one cycle
  // ahead and registered, so every pin value seen in a cycle belongs to the
  // state held in that cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_half_nxt     = r_half;
    w_tx_nxt       = r_tx;
    w_rx_nxt       = r_rx;
    w_id_nxt       = r_id;
    w_last_id_nxt  = r_last_id;
    w_csn_nxt      = r_csn;
    w_sck_nxt      = r_sck;
    w_mosi_nxt     = r_mosi;
    w_rsp_vld_nxt  = 1'b0;
    w_rsp_id_nxt   = r_rsp_id;
    w_rsp_data_nxt = r_rsp_data;

    case (r_state)
      S_IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          w_state_nxt   = S_SETUP;
          w_cnt_nxt     = 4'd0;
          w_id_nxt      = w_gnt1;
          w_last_id_nxt = w_gnt1;
          w_tx_nxt      = w_sel_data;
          w_csn_nxt     = 1'b0;
          w_sck_nxt     = 1'b1;
          w_mosi_nxt    = w_sel_data[15];
        end
      end

      S_SETUP: begin
        if (w_half_end) begin
          // First falling edge: bit 15 is already on mosi, so no shift here
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = 4'd0;
          w_half_nxt  = 5'd0;
          w_sck_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      S_SHIFT: begin
        if (w_half_end) begin
          w_cnt_nxt = 4'd0;
          if (r_half == C_LAST_HALF) begin
            // sck is already high after the 16th rising edge
            w_state_nxt = S_HOLD;
          end else begin
            w_half_nxt = r_half + 5'd1;
            w_sck_nxt  = ~r_half[0];
            if (!r_half[0]) begin
              // sck rising: capture the slave bit
              w_rx_nxt = {r_rx[14:0], spi_miso};
            end else begin
              // sck falling (never the first one): present the next bit
              w_tx_nxt   = {r_tx[14:0], 1'b0};
              w_mosi_nxt = r_tx[14];
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      S_HOLD: begin
        if (w_half_end) begin
          w_state_nxt    = S_GAP;
          w_cnt_nxt      = 4'd0;
          w_csn_nxt      = 1'b1;
          w_sck_nxt      = 1'b1;
          w_mosi_nxt     = 1'b0;
          w_rsp_vld_nxt  = 1'b1;
          w_rsp_id_nxt   = r_id;
          w_rsp_data_nxt = r_rx;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      S_GAP: begin
        if (r_cnt == C_GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        w_csn_nxt   = 1'b1;
        w_sck_nxt   = 1'b1;
        w_mosi_nxt  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_half     <= 5'd0;
      r_tx       <= 16'd0;
      r_rx       <= 16'd0;
      r_id       <= 1'b0;
      r_last_id  <= 1'b1;
      r_csn      <= 1'b1;
      r_sck      <= 1'b1;
      r_mosi     <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_half     <= w_half_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_id       <= w_id_nxt;
      r_last_id  <= w_last_id_nxt;
      r_csn      <= w_csn_nxt;
      r_sck      <= w_sck_nxt;
      r_mosi     <= w_mosi_nxt;
      r_rsp_vld  <= w_rsp_vld_nxt;
      r_rsp_id   <= w_rsp_id_nxt;
      r_rsp_data <= w_rsp_data_nxt;
    end
  end

  assign req0_rdy = w_gnt0;
  assign req1_rdy = w_gnt1;
  assign rsp_vld  = r_rsp_vld;
  assign rsp_id   = r_rsp_id;
  assign rsp_data = r_rsp_data;
  assign busy     = (r_state != S_IDLE);
  assign spi_csn  = r_csn;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arb
// Purpose  : Directed self-checking bench for spi_arb. Instance A runs with
//            SCK_HALF=5/GAP=4, instance B with SCK_HALF=1/GAP=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arb;

  localparam int SH_A  = 5;
  localparam int GAP_A = 4;
  localparam int SH_B  = 1;
  localparam int GAP_B = 4;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  // Instance A
  logic        rst_a, req0_vld_a, req1_vld_a, req0_rdy_a, req1_rdy_a;
  logic [15:0] req0_data_a, req1_data_a, rsp_data_a;
  logic        rsp_vld_a, rsp_id_a, busy_a, csn_a, sck_a, mosi_a, miso_a;
  logic        miso_tie;
  assign miso_a = miso_tie ? 1'b1 : mosi_a;

  // Instance B
  logic        rst_b, req0_vld_b, req1_vld_b, req0_rdy_b, req1_rdy_b;
  logic [15:0] req0_data_b, req1_data_b, rsp_data_b;
  logic        rsp_vld_b, rsp_id_b, busy_b, csn_b, sck_b, mosi_b, miso_b;
  assign miso_b = mosi_b;

  spi_arb #(.SCK_HALF(SH_A), .GAP(GAP_A)) u_dut_a (
    .clk_sys  (clk_sys),
    .rst      (rst_a),
    .req0_vld (req0_vld_a),
    .req0_data(req0_data_a),
    .req0_rdy (req0_rdy_a),
    .req1_vld (req1_vld_a),
    .req1_data(req1_data_a),
    .req1_rdy (req1_rdy_a),
    .rsp_vld  (rsp_vld_a),
    .rsp_id   (rsp_id_a),
    .rsp_data (rsp_data_a),
    .busy     (busy_a),
    .spi_csn  (csn_a),
    .spi_sck  (sck_a),
    .spi_mosi (mosi_a),
    .spi_miso (miso_a)
  );

  spi_arb #(.SCK_HALF(SH_B), .GAP(GAP_B)) u_dut_b (
    .clk_sys  (clk_sys),
    .rst      (rst_b),
    .req0_vld (req0_vld_b),
    .req0_data(req0_data_b),
    .req0_rdy (req0_rdy_b),
    .req1_vld (req1_vld_b),
    .req1_data(req1_data_b),
    .req1_rdy (req1_rdy_b),
    .rsp_vld  (rsp_vld_b),
    .rsp_id   (rsp_id_b),
    .rsp_data (rsp_data_b),
    .busy     (busy_b),
    .spi_csn  (csn_b),
    .spi_sck  (sck_b),
    .spi_mosi (mosi_b),
    .spi_miso (miso_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Wait (bounded) for a grant pulse on instance A; returns at the negedge
  // of the grant cycle T.
  task automatic wait_grant_a(input string tag, output int t, output logic id);
    bit found;
    found = 1'b0;
    t     = cyc;
    id    = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_sys);
      if (req0_rdy_a || req1_rdy_a) begin
        found = 1'b1;
        t     = cyc;
        id    = req1_rdy_a;
      end
    end
    check({tag, "_grant_seen"}, 32'(found), 32'd1);
  endtask

  // Observe cycles T+1 .. T+34*SH_A+1 of a frame granted in cycle T.
  task automatic observe_frame_a(input string tag, input logic exp_id,
                                 input logic [15:0] exp_data, input bit chk_mosi0);
    int          low, rises, rsp_at, rdy_cnt, nrsp;
    logic        prev_sck, mosi_seen, id;
    logic [15:0] d;
    low = 0; rises = 0; rsp_at = 0; rdy_cnt = 0; nrsp = 0;
    prev_sck = 1'b1; mosi_seen = 1'b0; id = 1'b0; d = 16'd0;
    for (int i = 1; i <= 34 * SH_A + 1; i++) begin
      @(negedge clk_sys);
      if (!csn_a) low++;
      if (!csn_a && sck_a && !prev_sck) rises++;
      prev_sck = sck_a;
      if (!csn_a && mosi_a) mosi_seen = 1'b1;
      if (req0_rdy_a || req1_rdy_a) rdy_cnt++;
      if (rsp_vld_a) begin
        nrsp++;
        rsp_at = i;
        d      = rsp_data_a;
        id     = rsp_id_a;
      end
    end
    check({tag, "_csn_low"},    32'(low),     32'(34 * SH_A));
    check({tag, "_sck_rises"},  32'(rises),   32'd16);
    check({tag, "_rsp_cycle"},  32'(rsp_at),  32'(34 * SH_A + 1));
    check({tag, "_rsp_count"},  32'(nrsp),    32'd1);
    check({tag, "_rsp_id"},     32'(id),      32'(exp_id));
    check({tag, "_rsp_data"},   32'(d),       32'(exp_data));
    check({tag, "_rdy_busy"},   32'(rdy_cnt), 32'd0);
    if (chk_mosi0) check({tag, "_mosi_zero"}, 32'(mosi_seen), 32'd0);
  endtask

  task automatic reset_a();
    @(posedge clk_sys);
    #1 rst_a = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 rst_a = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t, t_prev, cnt, low, rsp_at, rdy1_first, rdy1_cnt, nrsp;
    logic        id;
    logic [15:0] d;
    bit          found;

    rst_a = 1'b1; req0_vld_a = 1'b1; req1_vld_a = 1'b1;
    req0_data_a = 16'hA55A; req1_data_a = 16'h0000; miso_tie = 1'b0;
    rst_b = 1'b1; req0_vld_b = 1'b0; req1_vld_b = 1'b0;
    req0_data_b = 16'h5AA5; req1_data_b = 16'h0F0F;

    // ---- reset state, with both requests pending during reset ----
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_csn",      32'(csn_a),      32'd1);
    check("rst_sck",      32'(sck_a),      32'd1);
    check("rst_mosi",     32'(mosi_a),     32'd0);
    check("rst_rsp_vld",  32'(rsp_vld_a),  32'd0);
    check("rst_rsp_id",   32'(rsp_id_a),   32'd0);
    check("rst_rsp_data", 32'(rsp_data_a), 32'd0);
    check("rst_busy",     32'(busy_a),     32'd0);
    check("rst_rdy0",     32'(req0_rdy_a), 32'd0);
    check("rst_rdy1",     32'(req1_rdy_a), 32'd0);

    // ---- single requester 0, loopback, 0xA55A ----
    req1_vld_a = 1'b0;
    @(posedge clk_sys);
    #1 rst_a = 1'b0;
    wait_grant_a("f0", t, id);
    check("f0_id", 32'(id), 32'd0);
    @(posedge clk_sys);
    #1 req0_vld_a = 1'b0;
    observe_frame_a("f0", 1'b0, 16'hA55A, 1'b0);

    // ---- both held from reset: round-robin 0,1,0,1 ----
    // Back-to-back grants are 34*SH+GAP+1 apart: csn stays high for the GAP
    // cycles plus the IDLE grant cycle, since csn is registered.
    req0_data_a = 16'h1234; req1_data_a = 16'hBEEF;
    req0_vld_a = 1'b1; req1_vld_a = 1'b1;
    reset_a();
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant_a($sformatf("rr%0d", k), t, id);
      check($sformatf("rr%0d_id", k), 32'(id), 32'(k & 1));
      if (k > 0) begin
        check($sformatf("rr%0d_spacing", k), 32'(t - t_prev), 32'(34 * SH_A + GAP_A + 1));
        check($sformatf("rr%0d_rsp_hold", k), 32'(rsp_data_a),
              ((k & 1) == 1) ? 32'h1234 : 32'hBEEF);
      end
      t_prev = t;
      observe_frame_a($sformatf("rr%0d", k), 1'((k & 1)),
                      ((k & 1) == 1) ? 16'hBEEF : 16'h1234, 1'b0);
    end

    // ---- miso tied high, requester 1 sends zeros ----
    req0_vld_a = 1'b0; req1_vld_a = 1'b1; req1_data_a = 16'h0000; miso_tie = 1'b1;
    reset_a();
    wait_grant_a("ones", t, id);
    check("ones_id", 32'(id), 32'd1);
    @(posedge clk_sys);
    #1 req1_vld_a = 1'b0;
    observe_frame_a("ones", 1'b1, 16'hFFFF, 1'b1);
    miso_tie = 1'b0;

    // ---- reset during bit 8 aborts the frame ----
    req0_vld_a = 1'b1; req0_data_a = 16'h3C96;
    reset_a();
    wait_grant_a("abort", t, id);
    @(posedge clk_sys);
    #1 req0_vld_a = 1'b0;
    // bit b occupies T+6+10b .. T+15+10b with SCK_HALF=5
    while (cyc < t + 90) @(negedge clk_sys);
    check("abort_pre_csn", 32'(csn_a), 32'd0);
    @(posedge clk_sys);
    #1 rst_a = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("abort_csn",     32'(csn_a),     32'd1);
    check("abort_sck",     32'(sck_a),     32'd1);
    check("abort_mosi",    32'(mosi_a),    32'd0);
    check("abort_busy",    32'(busy_a),    32'd0);
    check("abort_rsp_vld", 32'(rsp_vld_a), 32'd0);
    @(posedge clk_sys);
    #1 rst_a = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (rsp_vld_a) cnt++;
    end
    check("abort_no_rsp", 32'(cnt), 32'd0);
    req0_vld_a = 1'b1; req0_data_a = 16'hC33C;
    wait_grant_a("post", t, id);
    check("post_id", 32'(id), 32'd0);
    @(posedge clk_sys);
    #1 req0_vld_a = 1'b0;
    observe_frame_a("post", 1'b0, 16'hC33C, 1'b0);

    // ---- instance B: SCK_HALF=1, req1 raised mid-frame of req0 ----
    @(posedge clk_sys);
    #1 rst_b = 1'b0;
    req0_vld_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk_sys);
      if (req0_rdy_b) found = 1'b1;
    end
    check("b_grant_seen", 32'(found), 32'd1);
    @(posedge clk_sys);
    #1 req0_vld_b = 1'b0;
    low = 0; rsp_at = 0; rdy1_first = 0; rdy1_cnt = 0; nrsp = 0; d = 16'd0; id = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_sys);
      if (!csn_b && rdy1_first == 0) low++;
      if (rsp_vld_b) begin
        nrsp++;
        rsp_at = i;
        d      = rsp_data_b;
        id     = rsp_id_b;
      end
      if (req1_rdy_b) begin
        rdy1_cnt++;
        if (rdy1_first == 0) rdy1_first = i;
      end
      if (i == 10) req1_vld_b = 1'b1;
    end
    check("b_csn_low",    32'(low),        32'(34 * SH_B));
    check("b_rsp_cycle",  32'(rsp_at),     32'(34 * SH_B + 1));
    check("b_rsp_count",  32'(nrsp),       32'd1);
    check("b_rsp_data",   32'(d),          32'h5AA5);
    check("b_rsp_id",     32'(id),         32'd0);
    check("b_rdy1_cycle", 32'(rdy1_first), 32'(34 * SH_B + GAP_B + 1));
    check("b_rdy1_count", 32'(rdy1_cnt),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
